// File: rtl/imem_loader.sv
// imem_loader: loads a framed byte stream (length, data, XOR checksum) into instruction memory
// and holds the core in reset until a verified image is present.
module imem_loader #(
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = (2**ADDR_W)/4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              CPU_RST,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);
   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} state_t;
   state_t            state_q, state_d;
   logic [15:0]       len_q, len_d, len_n;
   logic [17:0]       cnt_q, cnt_d;
   logic [7:0]        csum_q, csum_d, mem_wdata_q, mem_wdata_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [1:0]        err_code_q, err_code_d;
   logic              busy_q, busy_d, mem_we_q, mem_we_d, done_q, done_d, err_q, err_d, xfer;
   assign xfer  = in_valid & busy_q;
   assign len_n = {in_data, len_q[7:0]};
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      csum_d      = csum_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      err_code_d  = err_code_q;
      case (state_q)
         IDLE, DONE, ERROR: if (start) begin
            state_d    = LEN_LO;
            cnt_d      = '0;
            csum_d     = '0;
            err_code_d = 2'd0;
         end
         LEN_LO: if (xfer) begin
            len_d[7:0] = in_data;
            state_d    = LEN_HI;
         end
         LEN_HI: if (xfer) begin
            len_d[15:8] = in_data;
            state_d     = (len_n == 16'd0 || len_n > 16'(MAX_WORDS)) ? ERROR : DATA;
            err_code_d  = (state_d == ERROR) ? 2'd1 : 2'd0;
         end
         DATA: if (xfer) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = cnt_q[ADDR_W-1:0];
            mem_wdata_d = in_data;
            cnt_d       = cnt_q + 18'd1;
            csum_d      = csum_q ^ in_data;
            state_d     = (cnt_q == {len_q, 2'b00} - 18'd1) ? CHECK : DATA;
         end
         CHECK: if (xfer) begin
            state_d    = (in_data == csum_q) ? DONE : ERROR;
            err_code_d = (in_data == csum_q) ? 2'd0 : 2'd2;
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d inside {LEN_LO, LEN_HI, DATA, CHECK};
      done_d = state_d == DONE;
      err_d  = state_d == ERROR;
   end
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         csum_q      <= '0;
         busy_q      <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= 2'd0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         csum_q      <= csum_d;
         busy_q      <= busy_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
      end
   end
   assign in_ready  = busy_q;
   assign busy      = busy_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign done      = done_q;
   assign CPU_RST   = done_q;
   assign err       = err_q;
   assign err_code  = err_code_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives framed images into imem_loader; a queue scoreboard predicts every
// memory write and a memory model collects the written image.
module tb_imem_loader;
   logic       clk = 0, rst_n = 0, start = 0, in_valid = 0;
   logic [7:0] in_data = 0;
   logic       in_ready, mem_we, cpu_rst, busy, done, err;
   logic [7:0] mem_addr, mem_wdata;
   logic [1:0] err_code;
   int         total = 0, bad = 0;
   logic [15:0] exp_q[$];
   logic [7:0]  mem [256];
   logic [7:0]  img [256];
   logic [7:0]  t1[$], big[$];

   imem_loader dut (
      .CLK(clk), .RST(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .CPU_RST(cpu_rst), .busy(busy), .done(done), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // every transfer in DATA must show up as a write at the very next negedge, and nothing else
   always @(negedge clk) begin : mon
      logic [15:0] e;
      if (rst_n && (mem_we || exp_q.size() != 0)) begin
         check("we", 32'(mem_we), 32'(exp_q.size() != 0));
         if (mem_we && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("addr", 32'(mem_addr), 32'(e[15:8]));
            check("wdata", 32'(mem_wdata), 32'(e[7:0]));
         end
         if (mem_we) mem[mem_addr] = mem_wdata;
      end
   end

   task automatic pulse_start();
      start = 1;
      @(posedge clk); #1;
      start = 0;
   endtask

   task automatic send(input logic [7:0] b, input int gmax);
      int  g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
      bit  ok = 0;
      if (g > 0) begin
         in_valid = 0;
         repeat (g) begin @(posedge clk); #1; end
      end
      in_valid = 1;
      in_data  = b;
      for (int t = 0; t < 20 && !ok; t++) begin
         ok = in_ready;
         @(posedge clk); #1;
      end
      if (!ok) check("handshake_timeout", 0, 1);
   endtask

   task automatic load(input logic [7:0] d[$], input logic [7:0] cs, input int gmax, input bit mid_start);
      int n = d.size() / 4;
      send(8'(n), gmax);
      send(8'(n >> 8), gmax);
      foreach (d[i]) begin
         if (mid_start && i == 4) begin
            in_valid = 0;
            pulse_start();
            check("mid_start_busy", 32'(busy), 1);
         end
         send(d[i], gmax);
         exp_q.push_back({8'(i), d[i]});
         img[i] = d[i];
      end
      send(cs, gmax);
      in_valid = 0;
   endtask

   function automatic logic [7:0] xsum(input logic [7:0] d[$]);
      logic [7:0] s = 0;
      foreach (d[i]) s ^= d[i];
      return s;
   endfunction

   task automatic expect_result(input string tag, input logic ok, input logic [1:0] code);
      check({tag, "_done"}, 32'(done), 32'(ok));
      check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(ok));
      check({tag, "_err"}, 32'(err), 32'(!ok));
      check({tag, "_code"}, 32'(err_code), 32'(code));
      check({tag, "_busy"}, 32'(busy), 0);
   endtask

   task automatic check_img(input string tag, input int n);
      for (int i = 0; i < n; i++) check(tag, 32'(mem[i]), 32'(img[i]));
   endtask

   initial begin
      t1 = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
      for (int i = 0; i < 256; i++) big.push_back(8'($urandom));
      repeat (3) begin @(posedge clk); #1; end
      check("reset_outs", {in_ready, mem_we, done, err, busy, cpu_rst, mem_addr, mem_wdata, err_code}, 0);
      rst_n = 1;
      @(posedge clk); #1;
      // 1: nominal image
      pulse_start();
      load(t1, 8'h71, 0, 0);
      expect_result("t1", 1, 2'd0);
      check_img("t1_img", 8);
      // ignored traffic while DONE
      in_valid = 1;
      repeat (3) begin @(posedge clk); #1; end
      check("done_ready", 32'(in_ready), 0);
      in_valid = 0;
      // 2: bad checksum
      pulse_start();
      load(t1, 8'h70, 0, 0);
      expect_result("t2", 0, 2'd2);
      // 3: bad lengths then recovery
      pulse_start();
      send(8'h00, 0); send(8'h00, 0); in_valid = 0;
      expect_result("t3_zero", 0, 2'd1);
      pulse_start();
      send(8'h41, 0); send(8'h00, 0); in_valid = 0;
      expect_result("t3_65", 0, 2'd1);
      pulse_start();
      load(t1, 8'h71, 0, 0);
      expect_result("t3_ok", 1, 2'd0);
      // largest image fills all of memory
      pulse_start();
      load(big, xsum(big), 0, 0);
      expect_result("max", 1, 2'd0);
      check_img("max_img", 256);
      // 4: random gaps, start ignored mid-DATA
      pulse_start();
      load(t1, 8'h71, 3, 1);
      expect_result("t4", 1, 2'd0);
      check_img("t4_img", 8);
      // 5: reset mid-load
      pulse_start();
      send(8'h02, 0); send(8'h00, 0);
      for (int i = 0; i < 3; i++) begin
         send(t1[i], 0);
         exp_q.push_back({8'(i), t1[i]});
      end
      in_valid = 0;
      @(negedge clk); #1;
      rst_n = 0;
      #1;
      check("t5_rst_outs", {in_ready, mem_we, done, err, busy, cpu_rst, mem_addr, mem_wdata, err_code}, 0);
      @(posedge clk); #1;
      rst_n = 1;
      pulse_start();
      load(t1, 8'h71, 0, 0);
      expect_result("t5", 1, 2'd0);
      check_img("t5_img", 8);
      // 6: restart from DONE
      pulse_start();
      check("t6_cpu_rst", 32'(cpu_rst), 0);
      check("t6_busy", 32'(busy), 1);
      check("t6_done", 32'(done), 0);
      load(t1, 8'h71, 0, 0);
      expect_result("t6", 1, 2'd0);
      repeat (2) begin @(posedge clk); #1; end
      check("sb_empty", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
